// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, register index, and the EX->MEM pipeline entry.
package cpu_types_pkg;

  localparam int unsigned WordW = 32;
  localparam int unsigned RegW  = 5;

  typedef logic [WordW-1:0] word_t;
  typedef logic [RegW-1:0]  regbits_t;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_RSVD = 2'b11
  } brtype_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } exmem_state_t;

  typedef struct packed {
    word_t    result;
    word_t    pc;
    word_t    store_data;
    regbits_t rd;
    logic     regwen;
    logic     memren;
    logic     memwen;
  } exmem_t;

endpackage

// File: rtl/ex_branch_resolve.sv
// Combinational BEQ/BNE resolution from the ALU zero flag; reserved encoding is not a branch.
module ex_branch_resolve
  import cpu_types_pkg::*;
(
  input  logic [1:0]  br_type_i,
  input  logic        zero_i,
  input  logic [31:0] target_i,
  output logic        taken_o,
  output logic [31:0] target_o
);

  brtype_t br_type;
  assign br_type = brtype_t'(br_type_i);

  always_comb begin
    taken_o = 1'b0;
    case (br_type)
      BR_BEQ:  taken_o = zero_i;
      BR_BNE:  taken_o = ~zero_i;
      default: taken_o = 1'b0;
    endcase
  end

  assign target_o = target_i;

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM stage: two-entry skid buffer with registered branch redirect.
// Optional overflow trap enabled by defining EX_OVF_TRAP_EN.
module ex_mem_stage
  import cpu_types_pkg::*;
#(
  parameter int unsigned RW = 5
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          flush,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic [31:0]   alu_out,
  input  logic          alu_zero,
  input  logic          alu_overflow,
  input  logic          ex_ovf_chk,
  input  logic [31:0]   ex_pc,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_regwen,
  input  logic          ex_memren,
  input  logic          ex_memwen,
  input  logic [31:0]   ex_store_data,
  input  logic [1:0]    ex_br_type,
  input  logic [31:0]   ex_br_target,
  output logic          mem_valid,
  input  logic          mem_ready,
  output logic [31:0]   mem_result,
  output logic [31:0]   mem_pc,
  output logic [31:0]   mem_store_data,
  output logic [RW-1:0] mem_rd,
  output logic          mem_regwen,
  output logic          mem_memren,
  output logic          mem_memwen,
  output logic          br_taken,
  output logic [31:0]   br_target,
  output logic          trap_valid,
  output logic [31:0]   trap_epc
);

  exmem_state_t state_q, state_d;
  exmem_t       out_q, out_d;
  exmem_t       skid_q, skid_d;
  exmem_t       new_entry;
  logic         br_taken_q, br_taken_d;
  word_t        br_target_q, br_target_d;
  logic         accept, emit, ovf_hit;
  logic         res_taken;
  logic [31:0]  res_target;

  ex_branch_resolve u_branch (
    .br_type_i (ex_br_type),
    .zero_i    (alu_zero),
    .target_i  (ex_br_target),
    .taken_o   (res_taken),
    .target_o  (res_target)
  );

  assign ex_ready  = (state_q != FULL);
  assign mem_valid = (state_q != EMPTY);
  assign accept    = ex_valid & ex_ready;
  assign emit      = mem_valid & mem_ready;

  always_comb begin
    new_entry.result     = alu_out;
    new_entry.pc         = ex_pc;
    new_entry.store_data = ex_store_data;
    new_entry.rd         = regbits_t'(ex_rd);
    new_entry.regwen     = ex_regwen;
    new_entry.memren     = ex_memren;
    new_entry.memwen     = ex_memwen;
    ovf_hit              = 1'b0;
`ifdef EX_OVF_TRAP_EN
    ovf_hit = ex_ovf_chk & alu_overflow;
    // A trapping instruction must not commit any architectural side effect.
    if (ovf_hit) begin
      new_entry.regwen = 1'b0;
      new_entry.memren = 1'b0;
      new_entry.memwen = 1'b0;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            out_d   = new_entry;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && !emit) begin
            skid_d  = new_entry;
            state_d = FULL;
          end else if (accept && emit) begin
            out_d = new_entry;
          end else if (emit) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            out_d   = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    br_taken_d  = accept & res_taken & ~flush;
    br_target_d = br_taken_d ? res_target : '0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
    end
  end

  assign mem_result     = out_q.result;
  assign mem_pc         = out_q.pc;
  assign mem_store_data = out_q.store_data;
  assign mem_rd         = RW'(out_q.rd);
  assign mem_regwen     = out_q.regwen;
  assign mem_memren     = out_q.memren;
  assign mem_memwen     = out_q.memwen;
  assign br_taken       = br_taken_q;
  assign br_target      = br_target_q;

`ifdef EX_OVF_TRAP_EN
  logic  trap_valid_q, trap_valid_d;
  word_t trap_epc_q, trap_epc_d;

  always_comb begin
    trap_valid_d = accept & ovf_hit & ~flush;
    trap_epc_d   = trap_valid_d ? ex_pc : trap_epc_q;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      trap_valid_q <= 1'b0;
      trap_epc_q   <= '0;
    end else begin
      trap_valid_q <= trap_valid_d;
      trap_epc_q   <= trap_epc_d;
    end
  end

  assign trap_valid = trap_valid_q;
  assign trap_epc   = trap_epc_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_hit ^ ex_ovf_chk ^ alu_overflow;
  assign trap_valid = 1'b0;
  assign trap_epc   = '0;
`endif

endmodule
